// File: rtl/bbc_keyboard.sv
// rtl/bbc_keyboard.sv - BBC Micro keyboard matrix: event-driven key state, addressed/autoscan VIA read, clear sweep
module bbc_keyboard #(
   parameter logic [7:0] DIP_LINKS = 8'h00
) (
   input  logic       CLK_PROC,
   input  logic       RESET,
   input  logic       SCAN_EN,
   input  logic       nKBEN,
   input  logic [6:0] KEY_ADR,
   output logic       KEY_DOWN,
   output logic       CA2,
   input  logic       EV_VALID,
   input  logic [6:0] EV_CODE,
   input  logic       EV_MAKE,
   output logic       EV_READY,
   input  logic       CLEAR_ALL
);

   typedef enum logic {IDLE, CLEARING} state_t;

   state_t     state;
   logic [3:0] sweep;
   logic [3:0] scan_col;
   logic [7:0] matrix [10];

   logic [2:0] adr_row;
   logic [3:0] adr_col;
   logic [2:0] dip_idx;
   logic       adr_pressed;
   logic [3:0] ca2_col;
   logic       ca2_next;
   logic [2:0] ev_row;
   logic [3:0] ev_col;
   logic       ev_write;

   assign EV_READY = (state == IDLE) && !CLEAR_ALL;

   // Row 0 columns 2-9 are the startup links, not keys; columns 10-15 do not exist.
   always_comb begin
      adr_row     = KEY_ADR[6:4];
      adr_col     = KEY_ADR[3:0];
      dip_idx     = adr_col[2:0] - 3'd2;
      adr_pressed = 1'b0;
      if (adr_col <= 4'd9) begin
         if (adr_row == 3'd0 && adr_col >= 4'd2)
            adr_pressed = DIP_LINKS[dip_idx];
         else
            adr_pressed = matrix[adr_col][adr_row];
      end
   end

   always_comb begin
      ca2_col  = nKBEN ? scan_col : KEY_ADR[3:0];
      ca2_next = 1'b0;
      if (ca2_col <= 4'd9)
         ca2_next = |matrix[ca2_col][7:1];
   end

   always_comb begin
      ev_row   = EV_CODE[6:4];
      ev_col   = EV_CODE[3:0];
      ev_write = EV_VALID && EV_READY && (ev_col <= 4'd9) &&
                 !(ev_row == 3'd0 && ev_col >= 4'd2);
   end

   // Control FSM owns the matrix so event writes and the clear sweep never collide.
   always_ff @(posedge CLK_PROC or posedge RESET) begin
      if (RESET) begin
         state  <= IDLE;
         sweep  <= '0;
         matrix <= '{default: '0};
      end else begin
         case (state)
            IDLE: begin
               if (CLEAR_ALL) begin
                  state <= CLEARING;
                  sweep <= '0;
               end else if (ev_write) begin
                  matrix[ev_col][ev_row] <= EV_MAKE;
               end
            end
            CLEARING: begin
               if (CLEAR_ALL) begin
                  sweep <= '0;
               end else begin
                  matrix[sweep] <= '0;
                  if (sweep == 4'd9) begin
                     state <= IDLE;
                     sweep <= '0;
                  end else begin
                     sweep <= sweep + 4'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK_PROC or posedge RESET) begin
      if (RESET) begin
         scan_col <= '0;
         KEY_DOWN <= 1'b0;
         CA2      <= 1'b0;
      end else begin
         KEY_DOWN <= !nKBEN && adr_pressed;
         CA2      <= ca2_next;
         if (!nKBEN)
            scan_col <= KEY_ADR[3:0];
         else if (SCAN_EN)
            scan_col <= scan_col + 4'd1;
      end
   end

endmodule

// File: doc/bbc_keyboard.md
BBC_KEYBOARD -- requirements
Module: bbc_keyboard

Interface
REQ-001 Parameter DIP_LINKS, default 8'h00, startup link settings returned at row 0, columns 2-9 (bit n = column n+2).
REQ-002 CLK_PROC  in  1  processor clock; all state changes on its rising edge.
REQ-003 RESET  in  1  reset, asynchronous, active-high.
REQ-004 SCAN_EN  in  1  1 MHz clock-enable that advances the autoscan counter.
REQ-005 nKBEN  in  1  keyboard enable from addressable latch bit 3; 0 = addressed read, 1 = autoscan.
REQ-006 KEY_ADR  in  7  VIA port A[6:0]: row = [6:4], column = [3:0].
REQ-007 KEY_DOWN  out  1  VIA port A[7]: addressed key pressed.
REQ-008 CA2  out  1  VIA CA2: a key in rows 1-7 of the selected column is pressed.
REQ-009 EV_VALID  in  1  key event offered.
REQ-010 EV_CODE  in  7  event matrix address, same layout as KEY_ADR.
REQ-011 EV_MAKE  in  1  1 = press, 0 = release.
REQ-012 EV_READY  out  1  event accepted on an edge where EV_VALID & EV_READY.
REQ-013 CLEAR_ALL  in  1  single-cycle request to release every key.

Function
REQ-014 The key matrix SHALL have 8 rows × 10 columns (0-9), one bit per key; 1 = pressed.
REQ-015 An address with column 10-15 SHALL read as not pressed, SHALL contribute nothing to CA2, and SHALL be ignored by events, which are still accepted.
REQ-016 Row 0, columns 2-9 SHALL read DIP_LINKS[col-2]; events to those addresses SHALL be accepted and ignored.
REQ-017 An accepted event SHALL set (EV_MAKE=1) or clear (EV_MAKE=0) the addressed bit at the accepting edge.
REQ-018 KEY_DOWN SHALL be registered: each edge with nKBEN=0, KEY_DOWN <= pressed(KEY_ADR) using the matrix value before that edge; with nKBEN=1, KEY_DOWN <= 0.
REQ-019 An event accepted at edge N SHALL appear on KEY_DOWN after edge N+1.
REQ-020 SCAN_COL (4-bit) SHALL load KEY_ADR[3:0] each edge with nKBEN=0.
REQ-021 SCAN_COL SHALL increment on each edge with nKBEN=1 & SCAN_EN=1, wrapping 15->0, and SHALL hold otherwise.
REQ-022 CA2 SHALL be registered: CA2 <= OR of rows 1-7 of column (nKBEN ? SCAN_COL : KEY_ADR[3:0]); row 0, including the DIP links, SHALL be excluded.
REQ-023 Control FSM states SHALL be IDLE and CLEARING.
REQ-024 IDLE -> CLEARING on CLEAR_ALL=1, with sweep column SWEEP <= 0.
REQ-025 In CLEARING, each edge SHALL zero all 8 bits of column SWEEP and increment SWEEP; after column 9 is cleared the FSM SHALL return to IDLE (10 cycles).
REQ-026 CLEAR_ALL=1 while CLEARING SHALL restart the sweep at column 0.
REQ-027 EV_READY SHALL be combinational: (state==IDLE) & ~CLEAR_ALL; a simultaneous CLEAR_ALL and EV_VALID SHALL not accept the event.
REQ-028 EV_VALID held while EV_READY=0 SHALL not alter the matrix; the producer SHALL hold EV_CODE/EV_MAKE until accepted.
REQ-029 A make followed by a break for the same key in consecutive accepted cycles SHALL leave the bit 0.
REQ-030 KEY_ADR changing every cycle SHALL be tracked with exactly 1-cycle latency, with no hold or debounce.

Reset
REQ-031 On RESET=1 the block SHALL asynchronously clear the matrix, set SCAN_COL=0, SWEEP=0, state=IDLE, KEY_DOWN=0 and CA2=0.
REQ-032 RESET asserted mid-CLEARING SHALL abort the sweep; after release the FSM SHALL be in IDLE.
REQ-033 EV_READY SHALL read 1 on the first edge after RESET deasserts, unless CLEAR_ALL=1.

Verification
REQ-034 Make event with EV_CODE=7'h41 (row 4, col 1), then nKBEN=0 with KEY_ADR=7'h41 -> KEY_DOWN=1 one cycle later; KEY_ADR=7'h42 -> KEY_DOWN=0.
REQ-035 DIP_LINKS=8'hA5, nKBEN=0, KEY_ADR=7'h02..7'h09 in turn -> KEY_DOWN follows 1,0,1,0,0,1,0,1; CA2 stays 0.
REQ-036 Press 7'h35, then nKBEN=1 with SCAN_EN pulsing -> CA2=1 only in the cycle after SCAN_COL=5; SCAN_COL wraps 15->0.
REQ-037 Press 7'h10, 7'h79 and 7'h3C, then pulse CLEAR_ALL -> EV_READY=0 for 10 cycles; afterwards all keys read 0, except row 0 columns 2-9 still reading the DIP links.
REQ-038 CLEAR_ALL pulsed at cycle 5 of a sweep -> sweep restarts and EV_READY stays 0 for 10 further cycles.
REQ-039 RESET during CLEARING with EV_VALID held -> KEY_DOWN=0, CA2=0, EV_READY=1 after release, and the held event is accepted on the first edge.
